// File: rtl/lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lstm_seq_ctrl
//  Purpose  : Timestep sequencer for the LSTM array. Generates the
//             load / load_h / sel pattern for NUM_ITERATIONS timesteps per
//             sequence, runs back-to-back sequences, and provides a
//             start/busy/done handshake with stall (hold) and abort inputs.
//  Revision : 1.0  initial release
// ============================================================================
module lstm_seq_ctrl #(
    parameter int NUM_ITERATIONS = 8,
    parameter int FIRST_WAIT     = 44,
    parameter int CALC_CYCLES    = 43,
    parameter int CNT_WIDTH      = 16,
    parameter int STEP_WIDTH     = 3,
    parameter int SEQ_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [SEQ_WIDTH-1:0]  i_num_seq,
    input  logic                  i_hold,
    input  logic                  i_abort,
    output logic                  o_load,
    output logic                  o_load_h,
    output logic                  o_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [STEP_WIDTH-1:0] o_step,
    output logic [SEQ_WIDTH-1:0]  o_seq,
    output logic                  o_last_step
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_LOAD  = 3'd2,
        S_LOADH = 3'd3,
        S_CALC  = 3'd4,
        S_TAIL  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Terminal counts: a wait of N cycles runs the counter 0..N-1.
    localparam logic [CNT_WIDTH-1:0]  C_PRE_LAST  = CNT_WIDTH'(FIRST_WAIT - 1);
    localparam logic [CNT_WIDTH-1:0]  C_CALC_LAST =
        CNT_WIDTH'((CALC_CYCLES > 0) ? (CALC_CYCLES - 1) : 0);
    localparam logic [STEP_WIDTH-1:0] C_STEP_LAST = STEP_WIDTH'(NUM_ITERATIONS - 1);
    // With no compute gap, LOADH chains straight into the next LOAD / tail exit.
    localparam logic                  C_NO_CALC   = (CALC_CYCLES == 0);
    localparam logic [CNT_WIDTH-1:0]  C_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] C_STEP_ONE  = STEP_WIDTH'(1);
    localparam logic [SEQ_WIDTH:0]    C_SEQ_ONE   = (SEQ_WIDTH + 1)'(1);

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [STEP_WIDTH-1:0] r_step;
    logic [SEQ_WIDTH-1:0]  r_seq;
    logic [SEQ_WIDTH-1:0]  r_num_seq;
    logic                  r_sel;

    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [STEP_WIDTH-1:0] w_step_nxt;
    logic [SEQ_WIDTH-1:0]  w_seq_nxt;
    logic [SEQ_WIDTH-1:0]  w_num_seq_nxt;
    logic                  w_sel_nxt;

    logic                  w_more_seq;
    logic                  w_step_is_last;
    logic [SEQ_WIDTH-1:0]  w_num_seq_eff;

    // Compare in one extra bit so r_seq+1 cannot wrap when num_seq is all ones.
    assign w_more_seq     = (({1'b0, r_seq} + C_SEQ_ONE) < {1'b0, r_num_seq});
    assign w_step_is_last = (r_step == C_STEP_LAST);
    // A requested count of zero runs a single sequence.
    assign w_num_seq_eff  = (i_num_seq == '0) ? SEQ_WIDTH'(1) : i_num_seq;

    // State register plus step/sequence/wait counters and the sel flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_step    <= '0;
            r_seq     <= '0;
            r_num_seq <= '0;
            r_sel     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_step    <= w_step_nxt;
            r_seq     <= w_seq_nxt;
            r_num_seq <= w_num_seq_nxt;
            r_sel     <= w_sel_nxt;
        end
    end

    // Next-state logic: waits, pulse states, step/sequence advance, abort.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_step_nxt    = r_step;
        w_seq_nxt     = r_seq;
        w_num_seq_nxt = r_num_seq;
        w_sel_nxt     = r_sel;

        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt   = S_PRE;
                    w_cnt_nxt     = '0;
                    w_step_nxt    = '0;
                    w_seq_nxt     = '0;
                    w_sel_nxt     = 1'b0;
                    w_num_seq_nxt = w_num_seq_eff;
                end
            end

            S_PRE: begin
                // A held cycle neither counts nor exits.
                if (!i_hold) begin
                    if (r_cnt == C_PRE_LAST) begin
                        w_state_nxt = S_LOAD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + C_CNT_ONE;
                    end
                end
            end

            S_LOAD: begin
                w_state_nxt = S_LOADH;
                // From step 1 on, the array takes the fed-back h.
                if (r_step != '0) begin
                    w_sel_nxt = 1'b1;
                end
            end

            S_LOADH: begin
                w_cnt_nxt = '0;
                if (!w_step_is_last) begin
                    if (C_NO_CALC) begin
                        w_state_nxt = S_LOAD;
                        w_step_nxt  = r_step + C_STEP_ONE;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end else if (!C_NO_CALC) begin
                    w_state_nxt = S_TAIL;
                end else if (w_more_seq) begin
                    w_state_nxt = S_PRE;
                    w_seq_nxt   = r_seq + SEQ_WIDTH'(1);
                    w_step_nxt  = '0;
                    w_sel_nxt   = 1'b0;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end

            S_CALC: begin
                if (!i_hold) begin
                    if (r_cnt == C_CALC_LAST) begin
                        w_state_nxt = S_LOAD;
                        w_cnt_nxt   = '0;
                        w_step_nxt  = r_step + C_STEP_ONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + C_CNT_ONE;
                    end
                end
            end

            S_TAIL: begin
                if (!i_hold) begin
                    if (r_cnt == C_CALC_LAST) begin
                        w_cnt_nxt = '0;
                        if (w_more_seq) begin
                            w_state_nxt = S_PRE;
                            w_seq_nxt   = r_seq + SEQ_WIDTH'(1);
                            w_step_nxt  = '0;
                            w_sel_nxt   = 1'b0;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_step_nxt  = '0;
                w_seq_nxt   = '0;
                w_sel_nxt   = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_step_nxt  = '0;
                w_seq_nxt   = '0;
                w_sel_nxt   = 1'b0;
            end
        endcase

        // Abort overrides everything outside IDLE and suppresses o_done.
        if ((r_state != S_IDLE) && i_abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_step_nxt  = '0;
            w_seq_nxt   = '0;
            w_sel_nxt   = 1'b0;
        end
    end

    // Outputs decode straight from registers, so an async reset clears them at once.
    assign o_load      = (r_state == S_LOAD);
    assign o_load_h    = (r_state == S_LOADH);
    assign o_done      = (r_state == S_DONE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_sel       = r_sel;
    assign o_step      = r_step;
    assign o_seq       = r_seq;
    assign o_last_step = o_busy && w_step_is_last;

endmodule
`default_nettype wire

// File: tb/tb_lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lstm_seq_ctrl
//  Purpose  : Self-checking bench for lstm_seq_ctrl. Directed vector tables
//             with hand-computed cycle positions, plus short hand-written
//             sequences for reset, abort and the zero-gap configuration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lstm_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic [7:0] i_num_seq;
    logic       i_hold;
    logic       i_abort;
    logic       o_load, o_load_h, o_sel, o_busy, o_done, o_last_step;
    logic [2:0] o_step;
    logic [7:0] o_seq;

    // Second instance: no compute gap, 3 steps, 1-cycle first wait.
    logic       start6;
    logic [7:0] num6;
    logic       load6, loadh6, sel6, busy6, done6, last6;
    logic [1:0] step6;
    logic [7:0] seq6;

    lstm_seq_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_num_seq   (i_num_seq),
        .i_hold      (i_hold),
        .i_abort     (i_abort),
        .o_load      (o_load),
        .o_load_h    (o_load_h),
        .o_sel       (o_sel),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_step      (o_step),
        .o_seq       (o_seq),
        .o_last_step (o_last_step)
    );

    lstm_seq_ctrl #(
        .NUM_ITERATIONS (3),
        .FIRST_WAIT     (1),
        .CALC_CYCLES    (0),
        .CNT_WIDTH      (16),
        .STEP_WIDTH     (2),
        .SEQ_WIDTH      (8)
    ) u_dut6 (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start6),
        .i_num_seq   (num6),
        .i_hold      (1'b0),
        .i_abort     (1'b0),
        .o_load      (load6),
        .o_load_h    (loadh6),
        .o_sel       (sel6),
        .o_busy      (busy6),
        .o_done      (done6),
        .o_step      (step6),
        .o_seq       (seq6),
        .o_last_step (last6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;    // edge index after which the record is sampled
        logic hold;   // i_hold driven after sampling
        logic abort;  // i_abort driven after sampling
        logic load;
        logic lh;
        logic sel;
        logic busy;
        logic done;
        logic last;
        int   step;
        int   seq;
    } vec_t;

    vec_t vq[$];
    int   cur;
    int   total;
    int   bad;
    int   n_done;
    int   n_load;
    int   n_overlap;

    // Running tallies of pulses seen on the main instance.
    always @(negedge clk) begin
        if (o_load && o_load_h) n_overlap++;
        if (o_done) n_done++;
        if (o_load) n_load++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int c, input bit h, input bit a, input bit ld, input bit lh,
                       input bit sel, input bit busy, input bit done, input bit last,
                       input int step, input int seq);
        vec_t v;
        v.cyc = c; v.hold = h; v.abort = a; v.load = ld; v.lh = lh; v.sel = sel;
        v.busy = busy; v.done = done; v.last = last; v.step = step; v.seq = seq;
        vq.push_back(v);
    endtask

    task automatic start_run(input int n);
        @(negedge clk);
        i_start   = 1'b1;
        i_num_seq = 8'(n);
        @(posedge clk);
        cur = 0;
        #1 i_start = 1'b0;
    endtask

    task automatic run_table(input string tag);
        foreach (vq[i]) begin
            while (cur < vq[i].cyc) begin
                @(posedge clk);
                cur++;
            end
            #1;
            chk($sformatf("%s@%0d load",   tag, vq[i].cyc), 32'(o_load),      32'(vq[i].load));
            chk($sformatf("%s@%0d load_h", tag, vq[i].cyc), 32'(o_load_h),    32'(vq[i].lh));
            chk($sformatf("%s@%0d sel",    tag, vq[i].cyc), 32'(o_sel),       32'(vq[i].sel));
            chk($sformatf("%s@%0d busy",   tag, vq[i].cyc), 32'(o_busy),      32'(vq[i].busy));
            chk($sformatf("%s@%0d done",   tag, vq[i].cyc), 32'(o_done),      32'(vq[i].done));
            chk($sformatf("%s@%0d last",   tag, vq[i].cyc), 32'(o_last_step), 32'(vq[i].last));
            chk($sformatf("%s@%0d step",   tag, vq[i].cyc), 32'(o_step),      32'(vq[i].step));
            chk($sformatf("%s@%0d seq",    tag, vq[i].cyc), 32'(o_seq),       32'(vq[i].seq));
            i_hold  = vq[i].hold;
            i_abort = vq[i].abort;
        end
        vq.delete();
    endtask

    // Single sequence with default parameters: loads at 44+45k, done after 404.
    task automatic load_t1();
        //   cyc  h  a  ld lh sel bsy dn lst step seq
        add(0,    0, 0, 0, 0, 0,  1,  0, 0,  0,   0);
        add(43,   0, 0, 0, 0, 0,  1,  0, 0,  0,   0);
        add(44,   0, 0, 1, 0, 0,  1,  0, 0,  0,   0);
        add(45,   0, 0, 0, 1, 0,  1,  0, 0,  0,   0);
        add(46,   0, 0, 0, 0, 0,  1,  0, 0,  0,   0);
        add(88,   0, 0, 0, 0, 0,  1,  0, 0,  0,   0);
        add(89,   0, 0, 1, 0, 0,  1,  0, 0,  1,   0);
        add(90,   0, 0, 0, 1, 1,  1,  0, 0,  1,   0);
        add(134,  0, 0, 1, 0, 1,  1,  0, 0,  2,   0);
        add(358,  0, 0, 0, 0, 1,  1,  0, 0,  6,   0);
        add(359,  0, 0, 1, 0, 1,  1,  0, 1,  7,   0);
        add(360,  0, 0, 0, 1, 1,  1,  0, 1,  7,   0);
        add(403,  0, 0, 0, 0, 1,  1,  0, 1,  7,   0);
        add(404,  0, 0, 0, 0, 1,  1,  1, 1,  7,   0);
        add(405,  0, 0, 0, 0, 0,  0,  0, 0,  0,   0);
    endtask

    int d0;
    int l0;
    logic [3:0] exp6_bits [9];  // {load, load_h, done, busy}
    logic       exp6_sel  [9];
    int         exp6_step [9];

    initial begin
        rst = 1'b1; i_start = 1'b0; i_num_seq = '0; i_hold = 1'b0; i_abort = 1'b0;
        start6 = 1'b0; num6 = 8'd1;
        total = 0; bad = 0; cur = 0;

        // Reset state
        #1;
        chk("reset load",   32'(o_load),      0);
        chk("reset load_h", 32'(o_load_h),    0);
        chk("reset sel",    32'(o_sel),       0);
        chk("reset busy",   32'(o_busy),      0);
        chk("reset done",   32'(o_done),      0);
        chk("reset step",   32'(o_step),      0);
        chk("reset seq",    32'(o_seq),       0);
        chk("reset last",   32'(o_last_step), 0);
        chk("reset busy6",  32'(busy6),       0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Abort beats start in IDLE
        @(negedge clk);
        i_start = 1'b1; i_abort = 1'b1; i_num_seq = 8'd1;
        @(posedge clk);
        #1 chk("abort_vs_start busy", 32'(o_busy), 0);
        i_start = 1'b0; i_abort = 1'b0;

        // T1: one sequence
        load_t1();
        d0 = n_done; l0 = n_load;
        start_run(1);
        run_table("T1");
        chk("T1 done count", 32'(n_done - d0), 1);
        chk("T1 load count", 32'(n_load - l0), 8);

        // T2: two sequences, second PRE restarts sel at 0
        //   cyc  h  a  ld lh sel bsy dn lst step seq
        add(360,  0, 0, 0, 1, 1,  1,  0, 1,  7,   0);
        add(403,  0, 0, 0, 0, 1,  1,  0, 1,  7,   0);
        add(404,  0, 0, 0, 0, 0,  1,  0, 0,  0,   1);
        add(447,  0, 0, 0, 0, 0,  1,  0, 0,  0,   1);
        add(448,  0, 0, 1, 0, 0,  1,  0, 0,  0,   1);
        add(449,  0, 0, 0, 1, 0,  1,  0, 0,  0,   1);
        add(493,  0, 0, 1, 0, 0,  1,  0, 0,  1,   1);
        add(494,  0, 0, 0, 1, 1,  1,  0, 0,  1,   1);
        add(807,  0, 0, 0, 0, 1,  1,  0, 1,  7,   1);
        add(808,  0, 0, 0, 0, 1,  1,  1, 1,  7,   1);
        add(809,  0, 0, 0, 0, 0,  0,  0, 0,  0,   0);
        d0 = n_done; l0 = n_load;
        start_run(2);
        run_table("T2");
        chk("T2 done count", 32'(n_done - d0), 1);
        chk("T2 load count", 32'(n_load - l0), 16);

        // T3: num_seq=0 runs one sequence
        add(44,   0, 0, 1, 0, 0,  1,  0, 0,  0,   0);
        add(403,  0, 0, 0, 0, 1,  1,  0, 1,  7,   0);
        add(404,  0, 0, 0, 0, 1,  1,  1, 1,  7,   0);
        add(405,  0, 0, 0, 0, 0,  0,  0, 0,  0,   0);
        add(448,  0, 0, 0, 0, 0,  0,  0, 0,  0,   0);
        d0 = n_done;
        start_run(0);
        run_table("T3");
        chk("T3 done count", 32'(n_done - d0), 1);

        // T4: 5 held cycles in step-3 CALC shift everything by 5;
        //     hold across step-5 LOAD/LOADH changes nothing.
        add(180,  0, 0, 0, 1, 1,  1,  0, 0,  3,   0);
        add(190,  1, 0, 0, 0, 1,  1,  0, 0,  3,   0);
        add(195,  0, 0, 0, 0, 1,  1,  0, 0,  3,   0);
        add(224,  0, 0, 0, 0, 1,  1,  0, 0,  3,   0);
        add(228,  0, 0, 0, 0, 1,  1,  0, 0,  3,   0);
        add(229,  0, 0, 1, 0, 1,  1,  0, 0,  4,   0);
        add(230,  0, 0, 0, 1, 1,  1,  0, 0,  4,   0);
        add(274,  1, 0, 1, 0, 1,  1,  0, 0,  5,   0);
        add(275,  1, 0, 0, 1, 1,  1,  0, 0,  5,   0);
        add(276,  0, 0, 0, 0, 1,  1,  0, 0,  5,   0);
        add(319,  0, 0, 1, 0, 1,  1,  0, 0,  6,   0);
        add(364,  0, 0, 1, 0, 1,  1,  0, 1,  7,   0);
        add(408,  0, 0, 0, 0, 1,  1,  0, 1,  7,   0);
        add(409,  0, 0, 0, 0, 1,  1,  1, 1,  7,   0);
        add(410,  0, 0, 0, 0, 0,  0,  0, 0,  0,   0);
        d0 = n_done;
        start_run(1);
        run_table("T4");
        chk("T4 done count", 32'(n_done - d0), 1);

        // T5: abort in step-5 CALC, then a fresh start replays T1
        add(269,  0, 0, 1, 0, 1,  1,  0, 0,  5,   0);
        add(280,  0, 1, 0, 0, 1,  1,  0, 0,  5,   0);
        add(281,  0, 0, 0, 0, 0,  0,  0, 0,  0,   0);
        add(300,  0, 0, 0, 0, 0,  0,  0, 0,  0,   0);
        d0 = n_done;
        start_run(1);
        run_table("T5a");
        chk("T5 abort no done", 32'(n_done - d0), 0);
        load_t1();
        d0 = n_done;
        start_run(1);
        run_table("T5b");
        chk("T5 replay done count", 32'(n_done - d0), 1);

        // Async reset in the middle of a LOAD pulse
        start_run(1);
        while (cur < 44) begin
            @(posedge clk);
            cur++;
        end
        #1 chk("rst_mid before load", 32'(o_load), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid load",  32'(o_load), 0);
        chk("rst_mid busy",  32'(o_busy), 0);
        chk("rst_mid step",  32'(o_step), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("rst_mid idle after", 32'(o_busy), 0);

        // T6: zero-gap instance: load, load_h x3 back to back, then done
        exp6_bits = '{4'b0001, 4'b1001, 4'b0101, 4'b1001, 4'b0101,
                      4'b1001, 4'b0101, 4'b0011, 4'b0000};
        exp6_sel  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp6_step = '{0, 0, 0, 1, 1, 2, 2, 2, 0};
        @(negedge clk);
        start6 = 1'b1; num6 = 8'd1;
        @(posedge clk);
        #1 start6 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("T6@%0d pulses", k), 32'({load6, loadh6, done6, busy6}), 32'(exp6_bits[k]));
            chk($sformatf("T6@%0d sel", k),    32'(sel6),  32'(exp6_sel[k]));
            chk($sformatf("T6@%0d step", k),   32'(step6), 32'(exp6_step[k]));
        end

        chk("load/load_h overlap", 32'(n_overlap), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
